led_zone_tx: RTL and testbench

- Stage directly downstream of mean_cal.
- On each frame-done pulse from mean_cal, captures the eight 12-bit zone colours (4-bit R/G/B per zone).
- Expands each channel to 8 bits and serialises the 192-bit frame onto a 3-wire shift/latch link (sclk/sdo/latch) feeding the external LED driver chain.
- Runs in the 150 MHz video clock domain.

---
 rtl/led_pkg.sv | 39 +++
 rtl/led_sclk_gen.sv | 40 ++++
 rtl/led_zone_tx.sv | 144 ++++++++++++++
 tb/tb_led_zone_tx.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types, constants and channel expansion for the LED zone transmitter.
// Build option: define LED_GAMMA_EN to expand 4-bit channels through the gamma LUT
// instead of nibble replication.
package led_pkg;

    localparam int unsigned ZONE_BITS        = 12;
    localparam int unsigned TX_BITS_PER_ZONE = 24;

    // One zone colour as delivered by mean_cal; r occupies the top nibble.
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } zone_rgb_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } led_state_t;

`ifdef LED_GAMMA_EN
    localparam logic [7:0] GAMMA_LUT [16] = '{
        8'd0,   8'd1,   8'd3,   8'd7,   8'd14,  8'd23,  8'd34,  8'd48,
        8'd64,  8'd83,  8'd105, 8'd129, 8'd156, 8'd186, 8'd219, 8'd255
    };
`endif

    // Widen one 4-bit channel to the 8-bit value sent to the driver.
    function automatic logic [7:0] expand4to8(input logic [3:0] c);
`ifdef LED_GAMMA_EN
        return GAMMA_LUT[c];
`else
        return {c, c};
`endif
    endfunction

endpackage

// File: rtl/led_sclk_gen.sv
// Serial clock generator: CLK_DIV cycles low then CLK_DIV cycles high per bit,
// held low and idle whenever i_en is deasserted.
module led_sclk_gen
    import led_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise_c,
    output logic o_fall_c
);

    localparam int unsigned HP_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [HP_W-1:0] r_hp_cnt;
    logic            r_sclk;
    logic            w_wrap;

    assign w_wrap   = (r_hp_cnt == HP_W'(CLK_DIV - 1));
    assign o_rise_c = i_en & w_wrap & ~r_sclk;
    assign o_fall_c = i_en & w_wrap &  r_sclk;
    assign o_sclk   = r_sclk;

    // Half-period counter; sclk toggles each time it wraps.
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_hp_cnt <= '0;
            r_sclk   <= 1'b0;
        end else if (w_wrap) begin
            r_hp_cnt <= '0;
            r_sclk   <= ~r_sclk;
        end else begin
            r_hp_cnt <= r_hp_cnt + HP_W'(1);
        end
    end

endmodule

// File: rtl/led_zone_tx.sv
// Captures a frame of zone colours from mean_cal and shifts it out MSB first
// over sclk/sdo, followed by a latch strobe for the LED driver chain.
// Build option: LED_GAMMA_EN selects gamma-corrected channel expansion.
module led_zone_tx
    import led_pkg::*;
#(
    parameter int unsigned ZONES     = 8,
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned LATCH_CYC = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ZONE_BITS*ZONES-1:0] mean_i,
    input  logic                       start_i,
    output logic                       sclk_o,
    output logic                       sdo_o,
    output logic                       latch_o,
    output logic                       busy_o,
    output logic                       drop_o
);

    localparam int unsigned MEAN_W = ZONE_BITS * ZONES;
    localparam int unsigned TX_BITS = TX_BITS_PER_ZONE * ZONES;
    localparam int unsigned BIT_W  = $clog2(TX_BITS);
    localparam int unsigned LAT_W  = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;

    led_state_t          r_state;
    logic [MEAN_W-1:0]   r_mean;
    logic [TX_BITS-1:0]  r_shift;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic                r_last_bit;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic                r_sdo;
    logic                r_latch;
    logic                r_busy;
    logic                r_drop;

    logic [TX_BITS-1:0]  w_word;
    logic                w_sclk_en;
    logic                w_sclk;
    logic                w_rise_c;
    logic                w_fall_c;

    // Three expanded channels of one zone, R first.
    function automatic logic [TX_BITS_PER_ZONE-1:0] expand_zone(input zone_rgb_t zc);
        return {expand4to8(zc.r), expand4to8(zc.g), expand4to8(zc.b)};
    endfunction

    // Shift word from the captured colours; zone 0 lands in the MSBs.
    always_comb begin
        w_word = '0;
        for (int z = 0; z < int'(ZONES); z++) begin
            w_word[int'(TX_BITS) - 1 - z*int'(TX_BITS_PER_ZONE) -: TX_BITS_PER_ZONE] =
                expand_zone(zone_rgb_t'(r_mean[z*int'(ZONE_BITS) +: ZONE_BITS]));
        end
    end

    assign w_sclk_en = (r_state == ST_SHIFT);

    led_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_sclk_en),
        .o_sclk   (w_sclk),
        .o_rise_c (w_rise_c),
        .o_fall_c (w_fall_c)
    );

    // Frame sequencer: capture, load, shift, latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mean     <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_last_bit <= 1'b0;
            r_lat_cnt  <= '0;
            r_sdo      <= 1'b0;
            r_latch    <= 1'b0;
            r_busy     <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_drop <= start_i && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_mean  <= mean_i;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_shift    <= w_word;
                    r_sdo      <= w_word[TX_BITS-1];
                    r_bit_cnt  <= '0;
                    r_last_bit <= 1'b0;
                    r_state    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // Decide at the rising edge whether this is the final bit,
                    // so the falling edge only has to act on a flag.
                    if (w_rise_c) begin
                        r_last_bit <= (r_bit_cnt == BIT_W'(TX_BITS - 1));
                    end
                    if (w_fall_c) begin
                        if (r_last_bit) begin
                            r_last_bit <= 1'b0;
                            r_shift    <= '0;
                            r_sdo      <= 1'b0;
                            r_latch    <= 1'b1;
                            r_lat_cnt  <= '0;
                            r_state    <= ST_LATCH;
                        end else begin
                            r_shift   <= {r_shift[TX_BITS-2:0], 1'b0};
                            r_sdo     <= r_shift[TX_BITS-2];
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end
                end
                ST_LATCH: begin
                    if (r_lat_cnt == LAT_W'(LATCH_CYC - 1)) begin
                        r_latch <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + LAT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sclk_o  = w_sclk;
    assign sdo_o   = r_sdo;
    assign latch_o = r_latch;
    assign busy_o  = r_busy;
    assign drop_o  = r_drop;

endmodule

// File: tb/tb_led_zone_tx.sv
// Self-checking bench for led_zone_tx: frames are decoded off the serial link and
// compared with a reference word built from the colour/expansion rules.
module tb_led_zone_tx;

    localparam int unsigned ZONES     = 8;
    localparam int unsigned CLK_DIV   = 2;
    localparam int unsigned LATCH_CYC = 16;
    localparam int unsigned TXB       = 24 * ZONES;
    localparam int unsigned MW        = 12 * ZONES;
    localparam int FRAME_CYC = 1 + 2 * int'(TXB) * int'(CLK_DIV) + int'(LATCH_CYC);
    localparam int BUDGET    = 2 * FRAME_CYC + 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [MW-1:0] mean_i = '0;
    logic          sclk_o, sdo_o, latch_o, busy_o, drop_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Results of the most recent captured frame.
    logic [TXB-1:0] cap_bits;
    int cap_rises, cap_busy, cap_latch, cap_drops, cap_unstable, cap_dirty, cap_gap;
    bit cap_timeout;

    led_zone_tx #(
        .ZONES     (ZONES),
        .CLK_DIV   (CLK_DIV),
        .LATCH_CYC (LATCH_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mean_i  (mean_i),
        .start_i (start_i),
        .sclk_o  (sclk_o),
        .sdo_o   (sdo_o),
        .latch_o (latch_o),
        .busy_o  (busy_o),
        .drop_o  (drop_o)
    );

    always #5 clk = ~clk;

    // Reference channel expansion.
    function automatic logic [7:0] exp8(input logic [3:0] c);
`ifdef LED_GAMMA_EN
        int unsigned lut [16] = '{0, 1, 3, 7, 14, 23, 34, 48, 64, 83, 105, 129, 156, 186, 219, 255};
        return 8'(lut[c]);
`else
        return 8'(int'(c) * 17);
`endif
    endfunction

    // Reference serial word: zone 0 first, R then G then B.
    function automatic logic [TXB-1:0] model_word(input logic [MW-1:0] m);
        logic [TXB-1:0] w = '0;
        for (int z = 0; z < int'(ZONES); z++) begin
            logic [11:0] zv;
            zv = m[z*12 +: 12];
            w = {w[TXB-25:0], exp8(zv[11:8]), exp8(zv[7:4]), exp8(zv[3:0])};
        end
        return w;
    endfunction

    function automatic logic [MW-1:0] rand_mean();
        logic [MW-1:0] r = '0;
        for (int z = 0; z < int'(ZONES); z++) r[z*12 +: 12] = 12'($urandom);
        return r;
    endfunction

    function automatic logic [MW-1:0] fill_mean(input logic [11:0] v);
        logic [MW-1:0] r = '0;
        for (int z = 0; z < int'(ZONES); z++) r[z*12 +: 12] = v;
        return r;
    endfunction

    // Called at a negedge: pulse start_i across one posedge.
    task automatic pulse_start(input logic [MW-1:0] m);
        mean_i  = m;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Observe the link from the negedge after capture until busy_o drops.
    task automatic capture_frame(input int ovl_at, input bit toggle);
        bit   prev_sclk = 1'b0;
        logic held_sdo  = 1'b0;
        int   first_l = -1, last_l = -1;
        cap_bits = '0; cap_rises = 0; cap_busy = 0; cap_latch = 0;
        cap_drops = 0; cap_unstable = 0; cap_dirty = 0; cap_gap = 0;
        cap_timeout = 1'b1;
        for (int c = 0; c < BUDGET; c++) begin
            if (c > 0) @(negedge clk);
            if (!busy_o) begin
                cap_timeout = 1'b0;
                break;
            end
            cap_busy++;
            if (sclk_o && !prev_sclk) begin
                cap_bits = {cap_bits[TXB-2:0], sdo_o};
                cap_rises++;
                held_sdo = sdo_o;
            end else if (sclk_o && (sdo_o !== held_sdo)) begin
                cap_unstable++;
            end
            if (latch_o) begin
                cap_latch++;
                if (first_l < 0) first_l = c;
                last_l = c;
                if (sclk_o || sdo_o) cap_dirty++;
            end
            if (drop_o) cap_drops++;
            prev_sclk = sclk_o;
            start_i = (c == ovl_at);
            if (toggle) mean_i = rand_mean();
        end
        if (first_l >= 0) cap_gap = (last_l - first_l + 1) - cap_latch;
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({sclk_o, sdo_o, latch_o, busy_o, drop_o} !== 5'b0)
            $display("FAIL reset_outputs got=%b want=00000", {sclk_o, sdo_o, latch_o, busy_o, drop_o});
        else n_pass++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({sclk_o, sdo_o, latch_o, busy_o, drop_o} !== 5'b0)
            $display("FAIL idle_after_reset got=%b want=00000", {sclk_o, sdo_o, latch_o, busy_o, drop_o});
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [MW-1:0] m = fill_mean(12'h39D);
        pulse_start(m);
        capture_frame(-1, 1'b0);
        n_checks++;
        if (cap_timeout) $display("FAIL basic_timeout got=busy_stuck want=busy_fall");
        else n_pass++;
        n_checks++;
        if (cap_rises !== int'(TXB)) $display("FAIL basic_rises got=%0d want=%0d", cap_rises, TXB);
        else n_pass++;
        n_checks++;
        if (cap_bits !== model_word(m)) $display("FAIL basic_data got=%h want=%h", cap_bits, model_word(m));
        else n_pass++;
        n_checks++;
        if (cap_latch !== int'(LATCH_CYC)) $display("FAIL basic_latch_len got=%0d want=%0d", cap_latch, LATCH_CYC);
        else n_pass++;
        n_checks++;
        if (cap_gap !== 0 || cap_dirty !== 0)
            $display("FAIL basic_latch_shape got=gap%0d/dirty%0d want=0/0", cap_gap, cap_dirty);
        else n_pass++;
        n_checks++;
        if (cap_busy !== FRAME_CYC) $display("FAIL basic_busy_len got=%0d want=%0d", cap_busy, FRAME_CYC);
        else n_pass++;
        n_checks++;
        if (cap_unstable !== 0) $display("FAIL basic_sdo_stable got=%0d want=0", cap_unstable);
        else n_pass++;
        n_checks++;
        if (cap_drops !== 0) $display("FAIL basic_no_drop got=%0d want=0", cap_drops);
        else n_pass++;
    endtask

    task automatic test_zone_order();
        logic [MW-1:0] m = '0;
        for (int z = 0; z < int'(ZONES); z++) m[z*12 +: 12] = {4'(z), 4'(z), 4'(z)};
        pulse_start(m);
        capture_frame(-1, 1'b0);
        n_checks++;
        if (cap_bits !== model_word(m) || cap_rises !== int'(TXB))
            $display("FAIL zone_order got=%h/%0d want=%h/%0d", cap_bits, cap_rises, model_word(m), TXB);
        else n_pass++;
    endtask

    task automatic test_extremes();
        logic [TXB-1:0] want = '0;
        for (int z = 0; z < int'(ZONES); z++) want = {want[TXB-25:0], 8'hFF, 8'h00, 8'hFF};
        pulse_start(fill_mean(12'hF0F));
        capture_frame(-1, 1'b0);
        n_checks++;
        if (cap_bits !== want) $display("FAIL extreme_f0f got=%h want=%h", cap_bits, want);
        else n_pass++;
        pulse_start(fill_mean(12'h000));
        capture_frame(-1, 1'b0);
        n_checks++;
        if (cap_bits !== '0 || cap_rises !== int'(TXB))
            $display("FAIL extreme_zero got=%h/%0d want=0/%0d", cap_bits, cap_rises, TXB);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            logic [MW-1:0] m = rand_mean();
            pulse_start(m);
            capture_frame(-1, 1'b0);
            n_checks++;
            if (cap_bits !== model_word(m) || cap_busy !== FRAME_CYC)
                $display("FAIL random_%0d got=%h/%0d want=%h/%0d", k, cap_bits, cap_busy, model_word(m), FRAME_CYC);
            else n_pass++;
        end
    endtask

    task automatic test_overlap();
        logic [MW-1:0] m = rand_mean();
        int extra_busy = 0;
        pulse_start(m);
        capture_frame(50, 1'b0);
        n_checks++;
        if (cap_drops !== 1) $display("FAIL overlap_drop got=%0d want=1", cap_drops);
        else n_pass++;
        n_checks++;
        if (cap_bits !== model_word(m) || cap_busy !== FRAME_CYC)
            $display("FAIL overlap_frame got=%h/%0d want=%h/%0d", cap_bits, cap_busy, model_word(m), FRAME_CYC);
        else n_pass++;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy_o || sclk_o) extra_busy++;
        end
        n_checks++;
        if (extra_busy !== 0) $display("FAIL overlap_no_second got=%0d want=0", extra_busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [MW-1:0] ma = rand_mean();
        logic [MW-1:0] mb = rand_mean();
        pulse_start(ma);
        capture_frame(-1, 1'b0);
        pulse_start(mb);
        n_checks++;
        if (busy_o !== 1'b1 || drop_o !== 1'b0)
            $display("FAIL b2b_accept got=busy%b/drop%b want=busy1/drop0", busy_o, drop_o);
        else n_pass++;
        capture_frame(-1, 1'b0);
        n_checks++;
        if (cap_bits !== model_word(mb) || cap_busy !== FRAME_CYC)
            $display("FAIL b2b_frame got=%h/%0d want=%h/%0d", cap_bits, cap_busy, model_word(mb), FRAME_CYC);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [MW-1:0] m = rand_mean();
        bit prev = 1'b0;
        int rises = 0;
        int stray = 0;
        pulse_start(m);
        for (int c = 0; c < BUDGET && rises < 101; c++) begin
            if (sclk_o && !prev) rises++;
            prev = sclk_o;
            if (rises < 101) @(negedge clk);
        end
        n_checks++;
        if (rises !== 101) $display("FAIL rstmid_reach got=%0d want=101", rises);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({sclk_o, sdo_o, latch_o, busy_o, drop_o} !== 5'b0)
            $display("FAIL rstmid_outputs got=%b want=00000", {sclk_o, sdo_o, latch_o, busy_o, drop_o});
        else n_pass++;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (busy_o || sclk_o || latch_o) stray++;
        end
        n_checks++;
        if (stray !== 0) $display("FAIL rstmid_idle got=%0d want=0", stray);
        else n_pass++;
        m = rand_mean();
        pulse_start(m);
        capture_frame(-1, 1'b0);
        n_checks++;
        if (cap_bits !== model_word(m) || cap_rises !== int'(TXB))
            $display("FAIL rstmid_next got=%h/%0d want=%h/%0d", cap_bits, cap_rises, model_word(m), TXB);
        else n_pass++;
    endtask

    task automatic test_stability();
        logic [MW-1:0] m = rand_mean();
        pulse_start(m);
        capture_frame(-1, 1'b1);
        n_checks++;
        if (cap_bits !== model_word(m) || cap_busy !== FRAME_CYC)
            $display("FAIL stability got=%h/%0d want=%h/%0d", cap_bits, cap_busy, model_word(m), FRAME_CYC);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zone_order();
        test_extremes();
        test_random();
        test_overlap();
        test_back_to_back();
        test_reset_mid();
        test_stability();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
